// File: rtl/fixed_complex_pkg.sv
// Shared definitions for the signed fixed-point complex arithmetic blocks:
// default Q format, FSM state encodings and a width helper.
package fixed_complex_pkg;

    // Default Q format: integer bits (sign included) and fractional bits.
    localparam int FC_QI = 3;
    localparam int FC_QF = 3;
    localparam int FC_N  = FC_QI + FC_QF;

    // Sequencing states shared by the iterative fixed-point blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        SIGN = 2'd3
    } fc_state_e;

    // Working width of the divider datapath. It must hold both the scaled
    // dividend |num| * 2^qf (2n+1+qf bits) and the divisor pre-shifted to
    // the top quotient bit, den * 2^(n-2) (3n-2 bits).
    function automatic int fc_div_width(input int n, input int qf);
        return 3 * n + qf;
    endfunction

endpackage

// File: rtl/div_uint_iter.sv
// Iterative unsigned restoring divider producing QW quotient bits, MSB first,
// one bit per step. The caller guarantees quotient < 2^QW.
module div_uint_iter #(
    parameter int W  = 21,
    parameter int QW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [W-1:0]  dividend_i,
    input  logic [W-1:0]  divisor_i,
    output logic [QW-1:0] quotient_o,
    output logic [QW-1:0] quotient_next_o,
    output logic [W-1:0]  remainder_o
);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  dsh_q;
    logic [QW-1:0] quo_q;
    logic          ge;
    logic [W-1:0]  rem_d;

    // One restoring step: subtract the shifted divisor when it fits.
    always_comb begin
        ge              = (rem_q >= dsh_q);
        rem_d           = ge ? (rem_q - dsh_q) : rem_q;
        quotient_next_o = (quo_q << 1) | QW'(ge);
    end

    // Load aligns the divisor with the top quotient bit; each step walks it down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            dsh_q <= '0;
            quo_q <= '0;
        end else if (load_i) begin
            rem_q <= dividend_i;
            dsh_q <= divisor_i << (QW - 1);
            quo_q <= '0;
        end else if (step_i) begin
            rem_q <= rem_d;
            dsh_q <= dsh_q >> 1;
            quo_q <= quotient_next_o;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/div_fixed_complex.sv
// Signed fixed-point complex divider y = a / b with a fixed N+1 cycle latency,
// saturation to the Q format and a divide-by-zero flag.
module div_fixed_complex
    import fixed_complex_pkg::*;
#(
    parameter int QI = FC_QI,
    parameter int QF = FC_QF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [QI+QF-1:0]   a_Re,
    input  logic signed [QI+QF-1:0]   a_Im,
    input  logic signed [QI+QF-1:0]   b_Re,
    input  logic signed [QI+QF-1:0]   b_Im,
    output logic                      out_valid,
    output logic signed [QI+QF-1:0]   y_Re,
    output logic signed [QI+QF-1:0]   y_Im,
    output logic                      bad_rep,
    output logic                      div_zero
);

    localparam int N  = QI + QF;
    localparam int QW = N - 1;
    localparam int W  = fc_div_width(N, QF);
    localparam int CW = (N > 2) ? $clog2(N - 1) : 1;

    localparam logic [CW-1:0] CNT_FIRST = CW'(N - 2);
    localparam logic [N-1:0]  Y_MAX     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  Y_MIN     = {1'b1, {(N-1){1'b0}}};

    // Captured operands
    logic signed [N-1:0] a_re_q, a_im_q, b_re_q, b_im_q;

    // Control and flag state
    fc_state_e     state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [CW-1:0] cnt_q;
    logic          dz_q;
    logic          sat_q  [2];
    logic          neg_q  [2];
    logic [N-1:0]  y_q    [2];
    logic          bad_rep_q;
    logic          div_zero_q;

    // Full-width numerators (index 0 = Re, 1 = Im) and the shared denominator
    logic signed [2*N:0]   num   [2];
    logic signed [2*N-1:0] sq_re, sq_im;
    logic [2*N-1:0]        den;
    logic [2*N:0]          mag   [2];
    logic                  sat_d [2];
    logic [QW-1:0]         qn    [2];
    logic [N-1:0]          y_d   [2];

    // Operands are only taken on an accepted handshake.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready_q) begin
            a_re_q <= a_Re;
            a_im_q <= a_Im;
            b_re_q <= b_Re;
            b_im_q <= b_Im;
        end
    end

    // a/b = a*conj(b) / |b|^2, evaluated exactly at full width.
    always_comb begin
        num[0] = a_re_q * b_re_q + a_im_q * b_im_q;
        num[1] = a_im_q * b_re_q - a_re_q * b_im_q;
        sq_re  = b_re_q * b_re_q;
        sq_im  = b_im_q * b_im_q;
        den    = $unsigned(sq_re) + $unsigned(sq_im);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            // Magnitude and overflow test: the quotient fits only below 2^(N-1).
            always_comb begin
                mag[gi]   = num[gi][2*N] ? $unsigned(-num[gi]) : $unsigned(num[gi]);
                sat_d[gi] = ((W'(mag[gi]) << QF) >= (W'(den) << (N - 1)));
            end

            div_uint_iter #(
                .W  (W),
                .QW (QW)
            ) u_div (
                .clk             (clk),
                .rst             (rst),
                .load_i          (state_q == LOAD),
                .step_i          (state_q == DIV),
                .dividend_i      (W'(mag[gi]) << QF),
                .divisor_i       (W'(den)),
                .quotient_o      (),
                .quotient_next_o (qn[gi]),
                .remainder_o     ()
            );

            // Final component value: zero, saturated, or truncated magnitude with sign.
            always_comb begin
                y_d[gi] = '0;
                if (!dz_q) begin
                    if (sat_q[gi]) begin
                        y_d[gi] = neg_q[gi] ? Y_MIN : Y_MAX;
                    end else if (neg_q[gi]) begin
                        y_d[gi] = -{1'b0, qn[gi]};
                    end else begin
                        y_d[gi] = {1'b0, qn[gi]};
                    end
                end
            end
        end
    endgenerate

    // Sequencer: the last DIV step registers the signed result so it is
    // presented during SIGN alongside the out_valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            bad_rep_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                sat_q[k] <= 1'b0;
                neg_q[k] <= 1'b0;
                y_q[k]   <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    dz_q  <= (den == '0);
                    cnt_q <= CNT_FIRST;
                    for (int k = 0; k < 2; k++) begin
                        sat_q[k] <= sat_d[k];
                        neg_q[k] <= num[k][2*N];
                    end
                    state_q <= DIV;
                end
                DIV: begin
                    if (cnt_q == '0) begin
                        y_q[0]      <= y_d[0];
                        y_q[1]      <= y_d[1];
                        bad_rep_q   <= !dz_q && (sat_q[0] || sat_q[1]);
                        div_zero_q  <= dz_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SIGN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SIGN: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y_Re      = y_q[0];
    assign y_Im      = y_q[1];
    assign bad_rep   = bad_rep_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_fixed_complex.sv
// Directed testbench for div_fixed_complex in Q3.3 (1.0 = 8, latency 7).
module tb_div_fixed_complex;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [5:0] a_Re, a_Im, b_Re, b_Im;
    logic              out_valid;
    logic signed [5:0] y_Re, y_Im;
    logic              bad_rep;
    logic              div_zero;

    int checks = 0;
    int errors = 0;

    // Results of the last transaction
    int   got_re, got_im, lat;
    logic got_bad, got_dz, rdy_drive, rdy_busy;

    always #5 clk = ~clk;

    div_fixed_complex #(.QI(3), .QF(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_Re      (a_Re),
        .a_Im      (a_Im),
        .b_Re      (b_Re),
        .b_Im      (b_Im),
        .out_valid (out_valid),
        .y_Re      (y_Re),
        .y_Im      (y_Im),
        .bad_rep   (bad_rep),
        .div_zero  (div_zero)
    );

    // Issue one operation at the next falling edge and wait (bounded) for its result.
    task automatic do_op(input int ar, input int ai, input int br, input int bi);
        @(negedge clk);
        rdy_drive = in_ready;
        a_Re = 6'(ar); a_Im = 6'(ai); b_Re = 6'(br); b_Im = 6'(bi);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; rdy_busy = 1'b1;
        got_re = 0; got_im = 0; got_bad = 1'b0; got_dz = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) rdy_busy = in_ready;
            if (out_valid) begin
                lat = k; got_re = int'(y_Re); got_im = int'(y_Im);
                got_bad = bad_rep; got_dz = div_zero;
                break;
            end
        end
        $display("op a=(%0d,%0d) b=(%0d,%0d) -> y=(%0d,%0d) bad_rep=%0b div_zero=%0b latency=%0d",
                 ar, ai, br, bi, got_re, got_im, got_bad, got_dz, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0;
        a_Re = '0; a_Im = '0; b_Re = '0; b_Im = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (y_Re !== 6'sd0 || y_Im !== 6'sd0 || bad_rep !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs y=(%0d,%0d) bad_rep=%b div_zero=%b required 0", y_Re, y_Im, bad_rep, div_zero);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        // first edge after release must already accept
        do_op(16, 0, 8, 0);
        checks++;
        if (rdy_drive !== 1'b1 || lat !== 7 || got_re !== 16) begin
            errors++;
            $display("FAIL first_accept ready=%b latency=%0d y_Re=%0d required 1/7/16", rdy_drive, lat, got_re);
        end
    endtask

    task automatic test_basic;
        do_op(16, 0, 8, 0);
        checks++;
        if (got_re !== 16 || got_im !== 0) begin
            errors++;
            $display("FAIL basic_y got (%0d,%0d) required (16,0)", got_re, got_im);
        end
        checks++;
        if (got_bad !== 1'b0 || got_dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags bad_rep=%b div_zero=%b required 0/0", got_bad, got_dz);
        end
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL basic_latency got %0d required 7", lat);
        end
        checks++;
        if (rdy_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready in_ready=%b required 0", rdy_busy);
        end
    endtask

    task automatic test_rotation;
        do_op(8, 0, 0, 8);
        checks++;
        if (got_re !== 0 || got_im !== -8 || lat !== 7) begin
            errors++;
            $display("FAIL inv_i got (%0d,%0d) latency %0d required (0,-8) latency 7", got_re, got_im, lat);
        end
        do_op(8, 8, 8, 8);
        checks++;
        if (got_re !== 8 || got_im !== 0 || got_bad !== 1'b0) begin
            errors++;
            $display("FAIL self_div got (%0d,%0d) bad_rep=%b required (8,0) 0", got_re, got_im, got_bad);
        end
    endtask

    task automatic test_truncation;
        do_op(8, 0, 24, 0);
        checks++;
        if (got_re !== 2 || got_im !== 0) begin
            errors++;
            $display("FAIL trunc_pos got (%0d,%0d) required (2,0)", got_re, got_im);
        end
        do_op(-8, 0, 24, 0);
        checks++;
        if (got_re !== -2 || got_im !== 0) begin
            errors++;
            $display("FAIL trunc_neg got (%0d,%0d) required (-2,0)", got_re, got_im);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (y_Re !== -6'sd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_result y_Re=%0d out_valid=%b required -2/0", y_Re, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        a_Re = 6'sd16; a_Im = 6'sd0; b_Re = 6'sd8; b_Im = 6'sd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_Re !== 6'sd0) begin
            errors++;
            $display("FAIL mid_reset_async in_ready=%b out_valid=%b y_Re=%0d required 1/0/0", in_ready, out_valid, y_Re);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_discard out_valid_seen=%b in_ready=%b required 0/1", seen, in_ready);
        end
        $display("op aborted by reset at cycle 3");
    endtask

    task automatic test_saturation;
        do_op(31, -31, 1, 0);
        checks++;
        if (got_re !== 31 || got_im !== -32 || got_bad !== 1'b1 || lat !== 7) begin
            errors++;
            $display("FAIL sat_both got (%0d,%0d) bad_rep=%b latency %0d required (31,-32) 1 7", got_re, got_im, got_bad, lat);
        end
        do_op(-32, 0, 1, 0);
        checks++;
        if (got_re !== -32 || got_im !== 0 || got_bad !== 1'b1) begin
            errors++;
            $display("FAIL sat_re_only got (%0d,%0d) bad_rep=%b required (-32,0) 1", got_re, got_im, got_bad);
        end
    endtask

    task automatic test_div_zero;
        do_op(5, -7, 0, 0);
        checks++;
        if (got_dz !== 1'b1 || got_bad !== 1'b0) begin
            errors++;
            $display("FAIL dz_flags div_zero=%b bad_rep=%b required 1/0", got_dz, got_bad);
        end
        checks++;
        if (got_re !== 0 || got_im !== 0 || lat !== 7) begin
            errors++;
            $display("FAIL dz_y got (%0d,%0d) latency %0d required (0,0) latency 7", got_re, got_im, lat);
        end
        do_op(31, -31, 0, 0);
        checks++;
        if (got_dz !== 1'b1 || got_bad !== 1'b0 || got_re !== 0 || got_im !== 0) begin
            errors++;
            $display("FAIL dz_big got (%0d,%0d) div_zero=%b bad_rep=%b required (0,0) 1 0", got_re, got_im, got_dz, got_bad);
        end
    endtask

    task automatic test_back_to_back;
        do_op(16, 0, 8, 0);
        checks++;
        if (got_re !== 16 || got_dz !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got y_Re=%0d div_zero=%b required 16/0", got_re, got_dz);
        end
        // next op is driven in the cycle right after the out_valid pulse
        do_op(8, 0, 0, 8);
        checks++;
        if (rdy_drive !== 1'b1 || lat !== 7) begin
            errors++;
            $display("FAIL b2b_accept ready=%b latency=%0d required 1/7", rdy_drive, lat);
        end
        checks++;
        if (got_re !== 0 || got_im !== -8 || got_dz !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got (%0d,%0d) div_zero=%b required (0,-8) 0", got_re, got_im, got_dz);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rotation;
        test_truncation;
        test_reset_mid;
        test_saturation;
        test_div_zero;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
